// File: rtl/group_roulette.sv
// Roulette-style group selector: spins a highlighted index on flash ticks, decelerates after a
// button press and locks. Optional macro GROUP_MASK_EN adds a group eligibility mask.
module group_roulette #(
    parameter int unsigned NUM_GROUPS = 8,
    parameter int unsigned GW         = 3,
    parameter int unsigned SLOW_STEPS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            state,
    input  logic                  flash_tick,
    input  logic                  btn_down,
`ifdef GROUP_MASK_EN
    input  logic [NUM_GROUPS-1:0] group_mask,
`endif
    output logic [GW-1:0]         flash_cnt,
    output logic [GW-1:0]         selected_group,
    output logic                  spinning,
    output logic                  locked
);

    localparam int unsigned TW = SLOW_STEPS + 1;

    localparam logic [2:0] G_WAIT  = 3'd1;
    localparam logic [2:0] G_START = 3'd2;
    localparam logic [2:0] G_GET   = 3'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPIN  = 2'd1;
    localparam logic [1:0] S_DECEL = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    logic [1:0]    fsm, fsm_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt, tick_inc;
    logic [3:0]    div_exp, div_nxt;
    logic [3:0]    step_cnt, step_nxt, step_inc;
    logic [GW-1:0] flash_nxt, sel_nxt, adv_val;
    logic          clear, early;

    assign clear    = !(state == G_WAIT || state == G_START || state == G_GET);
    assign early    = (state == G_START) || (state == G_GET);
    assign tick_inc = tick_cnt + TW'(1);
    assign step_inc = step_cnt + 4'd1;

`ifdef GROUP_MASK_EN
    logic [NUM_GROUPS-1:0] elig;
    logic [GW-1:0]         hi_idx, lo_idx;
    logic                  hi_found;

    // Next eligible index above the current one, else the lowest eligible (may be itself)
    always_comb begin
        elig     = (group_mask == '0) ? '1 : group_mask;
        hi_idx   = flash_cnt;
        lo_idx   = flash_cnt;
        hi_found = 1'b0;
        for (int j = int'(NUM_GROUPS) - 1; j >= 0; j--) begin
            if (elig[j]) begin
                lo_idx = GW'(j);
                if (GW'(j) > flash_cnt) begin
                    hi_idx   = GW'(j);
                    hi_found = 1'b1;
                end
            end
        end
        adv_val = hi_found ? hi_idx : lo_idx;
    end
`else
    assign adv_val = (flash_cnt == GW'(NUM_GROUPS - 1)) ? '0 : flash_cnt + GW'(1);
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm            <= S_IDLE;
            flash_cnt      <= '0;
            selected_group <= '0;
            spinning       <= 1'b0;
            locked         <= 1'b0;
            tick_cnt       <= '0;
            div_exp        <= '0;
            step_cnt       <= '0;
        end else begin
            fsm            <= fsm_nxt;
            flash_cnt      <= flash_nxt;
            selected_group <= sel_nxt;
            spinning       <= (fsm_nxt == S_SPIN) || (fsm_nxt == S_DECEL);
            locked         <= (fsm_nxt == S_LOCK);
            tick_cnt       <= tick_nxt;
            div_exp        <= div_nxt;
            step_cnt       <= step_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        fsm_nxt   = fsm;
        flash_nxt = flash_cnt;
        sel_nxt   = selected_group;
        tick_nxt  = tick_cnt;
        div_nxt   = div_exp;
        step_nxt  = step_cnt;

        case (fsm)
            S_IDLE: begin
                if (state == G_WAIT) fsm_nxt = S_SPIN;
            end
            S_SPIN: begin
                sel_nxt = flash_cnt;
                if (early) begin
                    fsm_nxt = S_LOCK;
                end else begin
                    if (flash_tick) flash_nxt = adv_val;
                    if (btn_down) begin
                        fsm_nxt  = S_DECEL;
                        div_nxt  = 4'd1;
                        tick_nxt = '0;
                        step_nxt = '0;
                    end
                end
            end
            S_DECEL: begin
                sel_nxt = flash_cnt;
                if (early) begin
                    fsm_nxt = S_LOCK;
                end else if (flash_tick) begin
                    if (tick_inc == (TW'(1) << div_exp)) begin
                        flash_nxt = adv_val;
                        tick_nxt  = '0;
                        div_nxt   = div_exp + 4'd1;
                        step_nxt  = step_inc;
                        if (step_inc == 4'(SLOW_STEPS)) begin
                            fsm_nxt = S_LOCK;
                            sel_nxt = adv_val;
                        end
                    end else begin
                        tick_nxt = tick_inc;
                    end
                end
            end
            S_LOCK: begin
            end
            default: fsm_nxt = S_IDLE;
        endcase

        // Game leaving the round wins over everything else
        if (clear) begin
            fsm_nxt   = S_IDLE;
            flash_nxt = '0;
            sel_nxt   = '0;
            tick_nxt  = '0;
            div_nxt   = '0;
            step_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_group_roulette.sv
// Directed bench for group_roulette with NUM_GROUPS=6, GW=3, SLOW_STEPS=3.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_group_roulette;

    localparam logic [2:0] G_RESET = 3'd0;
    localparam logic [2:0] G_WAIT  = 3'd1;
    localparam logic [2:0] G_START = 3'd2;
    localparam logic [2:0] G_GET   = 3'd3;
    localparam logic [2:0] G_OVER  = 3'd4;

    logic       clk;
    logic       reset_n;
    logic [2:0] state;
    logic       flash_tick;
    logic       btn_down;
`ifdef GROUP_MASK_EN
    logic [5:0] group_mask;
`endif
    logic [2:0] flash_cnt;
    logic [2:0] selected_group;
    logic       spinning;
    logic       locked;

    int checks = 0;
    int errors = 0;

    group_roulette #(.NUM_GROUPS(6), .GW(3), .SLOW_STEPS(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .state          (state),
        .flash_tick     (flash_tick),
        .btn_down       (btn_down),
`ifdef GROUP_MASK_EN
        .group_mask     (group_mask),
`endif
        .flash_cnt      (flash_cnt),
        .selected_group (selected_group),
        .spinning       (spinning),
        .locked         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at a falling edge; pulses are dropped after the next falling edge
    task automatic drive(input logic [2:0] st, input logic ft, input logic bd);
        state      = st;
        flash_tick = ft;
        btn_down   = bd;
        @(negedge clk);
        flash_tick = 1'b0;
        btn_down   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        state   = G_RESET;
        repeat (2) @(negedge clk);
        checks++;
        if ({flash_cnt, selected_group, spinning, locked} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %h want 00", {flash_cnt, selected_group, spinning, locked});
        end
        reset_n = 1'b1;
        drive(G_RESET, 1'b1, 1'b1);
        checks++;
        if ({flash_cnt, selected_group, spinning, locked} !== 8'h00) begin
            errors++;
            $display("FAIL idle_in_reset_state got %h want 00", {flash_cnt, selected_group, spinning, locked});
        end
    endtask

    task automatic test_spin();
        logic [2:0] exp_cnt [7];
        logic [2:0] prev;
        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd3; exp_cnt[3] = 3'd4;
        exp_cnt[4] = 3'd5; exp_cnt[5] = 3'd0; exp_cnt[6] = 3'd1;
        drive(G_WAIT, 1'b0, 1'b0);
        checks++;
        if ({spinning, locked, flash_cnt} !== 5'b10_000) begin
            errors++;
            $display("FAIL spin_entry got %b want 10000", {spinning, locked, flash_cnt});
        end
        prev = 3'd0;
        for (int i = 0; i < 7; i++) begin
            drive(G_WAIT, 1'b1, 1'b0);
            checks++;
            if (flash_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL spin_cnt[%0d] got %0d want %0d", i, flash_cnt, exp_cnt[i]);
            end
            checks++;
            if (selected_group !== prev || spinning !== 1'b1) begin
                errors++;
                $display("FAIL spin_sel[%0d] got sel=%0d spin=%b want sel=%0d spin=1", i, selected_group, spinning, prev);
            end
            prev = exp_cnt[i];
        end
        drive(G_WAIT, 1'b0, 1'b0);
        checks++;
        if (selected_group !== 3'd1) begin
            errors++;
            $display("FAIL spin_sel_catchup got %0d want 1", selected_group);
        end
    endtask

    task automatic test_decel();
        logic [2:0] exp;
        drive(G_WAIT, 1'b1, 1'b0);
        checks++;
        if (flash_cnt !== 3'd2) begin
            errors++;
            $display("FAIL decel_pre got %0d want 2", flash_cnt);
        end
        drive(G_WAIT, 1'b0, 1'b1);
        checks++;
        if ({spinning, locked, flash_cnt} !== 5'b10_010) begin
            errors++;
            $display("FAIL decel_entry got %b want 10010", {spinning, locked, flash_cnt});
        end
        for (int t = 1; t <= 14; t++) begin
            drive(G_WAIT, 1'b1, 1'b0);
            exp = (t < 2) ? 3'd2 : (t < 6) ? 3'd3 : (t < 14) ? 3'd4 : 3'd5;
            checks++;
            if (flash_cnt !== exp || locked !== (t == 14) || spinning !== (t < 14)) begin
                errors++;
                $display("FAIL decel_tick[%0d] got cnt=%0d lock=%b spin=%b want cnt=%0d lock=%b spin=%b",
                         t, flash_cnt, locked, spinning, exp, (t == 14), (t < 14));
            end
        end
        checks++;
        if (selected_group !== 3'd5) begin
            errors++;
            $display("FAIL decel_final_sel got %0d want 5", selected_group);
        end
        for (int k = 0; k < 3; k++) begin
            drive(G_WAIT, 1'b1, 1'b1);
            checks++;
            if ({flash_cnt, selected_group, locked} !== 7'b101_101_1) begin
                errors++;
                $display("FAIL lock_hold[%0d] got cnt=%0d sel=%0d lock=%b want 5 5 1", k, flash_cnt, selected_group, locked);
            end
        end
    endtask

    task automatic test_clear();
        drive(G_OVER, 1'b1, 1'b1);
        checks++;
        if ({flash_cnt, selected_group, spinning, locked} !== 8'h00) begin
            errors++;
            $display("FAIL clear_over got %h want 00", {flash_cnt, selected_group, spinning, locked});
        end
        drive(G_WAIT, 1'b0, 1'b0);
        checks++;
        if (spinning !== 1'b1) begin
            errors++;
            $display("FAIL clear_rewait got %b want 1", spinning);
        end
    endtask

    task automatic test_btn_tick();
        logic [2:0] exp;
        drive(G_WAIT, 1'b1, 1'b1);
        checks++;
        if ({spinning, locked, flash_cnt, selected_group} !== 8'b10_001_000) begin
            errors++;
            $display("FAIL btn_tick_same got %b want 10001000", {spinning, locked, flash_cnt, selected_group});
        end
        for (int k = 1; k <= 6; k++) begin
            drive(G_WAIT, 1'b1, 1'b0);
            exp = (k < 2) ? 3'd1 : (k < 6) ? 3'd2 : 3'd3;
            checks++;
            if (flash_cnt !== exp || spinning !== 1'b1) begin
                errors++;
                $display("FAIL btn_tick_decel[%0d] got cnt=%0d spin=%b want cnt=%0d spin=1", k, flash_cnt, spinning, exp);
            end
        end
    endtask

    task automatic test_early_lock();
        logic [2:0] st_seq [3];
        st_seq[0] = G_START; st_seq[1] = G_GET; st_seq[2] = G_WAIT;
        for (int k = 0; k < 3; k++) begin
            drive(st_seq[k], (k != 0), (k == 1));
            checks++;
            if ({locked, spinning, selected_group, flash_cnt} !== 8'b10_011_011) begin
                errors++;
                $display("FAIL early_lock[%0d] got %b want 10011011", k, {locked, spinning, selected_group, flash_cnt});
            end
        end
    endtask

`ifdef GROUP_MASK_EN
    task automatic test_mask();
        logic [2:0] exp_m [4];
        logic [2:0] exp_a [6];
        exp_m[0] = 3'd1; exp_m[1] = 3'd3; exp_m[2] = 3'd5; exp_m[3] = 3'd1;
        exp_a[0] = 3'd1; exp_a[1] = 3'd2; exp_a[2] = 3'd3; exp_a[3] = 3'd4; exp_a[4] = 3'd5; exp_a[5] = 3'd0;
        drive(G_OVER, 1'b0, 1'b0);
        group_mask = 6'b101010;
        drive(G_WAIT, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(G_WAIT, 1'b1, 1'b0);
            checks++;
            if (flash_cnt !== exp_m[i]) begin
                errors++;
                $display("FAIL mask_seq[%0d] got %0d want %0d", i, flash_cnt, exp_m[i]);
            end
        end
        group_mask = 6'b000010;
        drive(G_WAIT, 1'b1, 1'b0);
        checks++;
        if (flash_cnt !== 3'd1) begin
            errors++;
            $display("FAIL mask_single got %0d want 1", flash_cnt);
        end
        drive(G_OVER, 1'b0, 1'b0);
        group_mask = 6'b000000;
        drive(G_WAIT, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(G_WAIT, 1'b1, 1'b0);
            checks++;
            if (flash_cnt !== exp_a[i]) begin
                errors++;
                $display("FAIL mask_zero[%0d] got %0d want %0d", i, flash_cnt, exp_a[i]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_decel();
        drive(G_OVER, 1'b0, 1'b0);
        drive(G_WAIT, 1'b0, 1'b0);
        drive(G_WAIT, 1'b1, 1'b1);
        drive(G_WAIT, 1'b1, 1'b0);
        drive(G_WAIT, 1'b1, 1'b0);
        checks++;
        if (flash_cnt !== 3'd2 || spinning !== 1'b1) begin
            errors++;
            $display("FAIL mid_decel_pre got cnt=%0d spin=%b want cnt=2 spin=1", flash_cnt, spinning);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({flash_cnt, selected_group, spinning, locked} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got %h want 00", {flash_cnt, selected_group, spinning, locked});
        end
        flash_tick = 1'b1;
        repeat (3) @(negedge clk);
        flash_tick = 1'b0;
        checks++;
        if ({flash_cnt, selected_group, spinning, locked} !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got %h want 00", {flash_cnt, selected_group, spinning, locked});
        end
        reset_n = 1'b1;
        drive(G_WAIT, 1'b1, 1'b0);
        checks++;
        if ({spinning, locked, flash_cnt} !== 5'b10_000) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 10000", {spinning, locked, flash_cnt});
        end
        drive(G_WAIT, 1'b1, 1'b0);
        checks++;
        if (flash_cnt !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_spin got %0d want 1", flash_cnt);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        state      = G_RESET;
        flash_tick = 1'b0;
        btn_down   = 1'b0;
`ifdef GROUP_MASK_EN
        group_mask = 6'b000000;
`endif
        test_reset();
        test_spin();
        test_decel();
        test_clear();
        test_btn_tick();
        test_early_lock();
`ifdef GROUP_MASK_EN
        test_mask();
`endif
        test_reset_mid_decel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/group_roulette.md
# group_roulette

Parametrised group selector for the pinball game controller. While the game sits in WAIT it cycles a highlighted group index on each flash tick. A button press starts a deceleration phase: the highlight slows down over a fixed number of steps, then locks. The locked index drives `selected_group` for the rest of the round, until the game FSM returns to RESET or OVER.

## Interface
Parameters:
- `NUM_GROUPS`, default 8: number of selectable groups; legal range 2..2^GW.
- `GW`, default 3: width of the group index.
- `SLOW_STEPS`, default 4: number of decelerating advances before lock; legal range 1..8.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `state` input 3: game FSM state. RESET=0, WAIT=1, START=2, GET=3, OVER=4; values 5..7 are treated as RESET.
- `flash_tick` input 1: single-cycle enable pulse from the flash divider.
- `btn_down` input 1: single-cycle, debounced button pulse.
- `group_mask` input NUM_GROUPS: eligible-group mask. Present only with `GROUP_MASK_EN`.
- `flash_cnt` output GW: current highlighted index (registered).
- `selected_group` output GW: selection presented to the game (registered).
- `spinning` output 1: high in SPIN or DECEL.
- `locked` output 1: high in LOCK.

## Operation
Internal FSM has four states: IDLE, SPIN, DECEL, LOCK. All outputs are registered.

- **Reset.** `reset_n`=0 (any time, including mid-DECEL): FSM goes to IDLE; `flash_cnt`, `selected_group`, `spinning` and `locked` are all 0; all internal counters are 0.
- **Clear override.** `state` ∈ {RESET, OVER, 5..7} in any FSM state: next cycle FSM is IDLE, `flash_cnt`=0, `selected_group`=0.
- **IDLE.** `state`=WAIT → SPIN. `btn_down` and `flash_tick` are ignored.
- **SPIN.**
  - Each `flash_tick` advances `flash_cnt` (see Advance).
  - `selected_group` <= `flash_cnt`, i.e. it follows one cycle behind.
  - `btn_down` → DECEL with `div_exp`=1, `tick_cnt`=0, `step_cnt`=0.
  - `btn_down` and `flash_tick` in the same cycle: the advance and the transition both take effect.
- **DECEL.**
  - Each `flash_tick` increments `tick_cnt`.
  - On the tick that makes `tick_cnt` = 2^`div_exp`: advance `flash_cnt`, set `tick_cnt`=0, increment `div_exp` and `step_cnt`.
  - When `step_cnt` reaches SLOW_STEPS: → LOCK, and `selected_group` <= the new `flash_cnt`.
  - `btn_down` is ignored.
  - `selected_group` keeps following `flash_cnt`.
- **Early lock.** `state` ∈ {START, GET} while in SPIN or DECEL → LOCK next cycle, with `selected_group` <= current `flash_cnt`.
- **LOCK.**
  - `flash_cnt` and `selected_group` hold.
  - `btn_down` and `flash_tick` are ignored.
  - WAIT, START and GET all hold LOCK; only the clear override leaves it.
- **Advance.** `flash_cnt` <= (`flash_cnt`+1), wrapping from NUM_GROUPS-1 to 0. It never takes a value ≥ NUM_GROUPS.
- **Widths.**
  - `tick_cnt` is SLOW_STEPS+1 bits, so 2^SLOW_STEPS is representable.
  - `div_exp` and `step_cnt` are 4 bits.

## Timing
- Every output changes only on the `clk` rising edge, except on asynchronous reset.
- `flash_tick` in cycle n → new `flash_cnt` visible in cycle n+1; `selected_group` (SPIN/DECEL) in cycle n+2.
- `btn_down` in cycle n → `spinning` still 1 and DECEL active from cycle n+1.
- Final DECEL advance in cycle n → `flash_cnt` and `selected_group` hold the final value, with `locked`=1 and `spinning`=0, from cycle n+1.
- Total ticks from `btn_down` to lock: 2+4+…+2^SLOW_STEPS = 2^(SLOW_STEPS+1)−2.
- Clear override or early lock takes effect exactly one cycle after `state` changes.

## Configuration
Macro: `GROUP_MASK_EN`.

- **Defined.**
  - The `group_mask` port exists.
  - Advance moves to the next index, counting upward with wrap, whose mask bit is 1. The search is combinational within a single cycle.
  - If the current index is the only eligible one, it stays.
  - `group_mask`=0 means all groups are eligible.
  - Mask changes apply to the next advance only; an already-locked value is never altered.
- **Undefined.** No `group_mask` port; every group is eligible; Advance is a plain modulo increment.

## Test plan
All scenarios use NUM_GROUPS=6, GW=3, SLOW_STEPS=3.

1. `reset_n` low for 3 cycles in the middle of DECEL → all outputs 0; after release the FSM is in IDLE.
2. `state`=WAIT, then 7 `flash_tick` pulses → `flash_cnt` sequence 1,2,3,4,5,0,1; `selected_group` trails by one cycle; `spinning`=1.
3. `btn_down` at `flash_cnt`=2, then 14 ticks → advances on ticks 2, 6 and 14 giving 3, 4, 5; `locked`=1 and `selected_group`=5 one cycle after tick 14; further ticks and `btn_down` leave it unchanged.
4. In DECEL at `flash_cnt`=3, `state`→START → next cycle `locked`=1 and `selected_group`=3; then `state`=GET → it holds 3.
5. In LOCK with `selected_group`=5, `state`→OVER → next cycle `selected_group`=0, `flash_cnt`=0, `locked`=0; then `state`=WAIT → `spinning`=1.
6. With `GROUP_MASK_EN` and `group_mask`=6'b101010, spinning from 0 → sequence 1,3,5,1; with `group_mask`=0 → 1,2,3,4,5,0.
